// File: rtl/window_arbiter.sv
// Round-robin arbiter feeding one registered output slot from LEVELS pyramid window streams.
// Optional per-level grant and stall counters are enabled with `define WINDOW_ARB_STATS_EN.
module window_arbiter #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int LEVELS       = 7,
  localparam int LVL_W       = $clog2(LEVELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WINDOW_WIDTH*LEVELS-1:0] win_in,
  input  logic [LEVELS-1:0]              win_valid_in,
  output logic [LEVELS-1:0]              win_ready_out,
  output logic [WINDOW_WIDTH-1:0]        win_out,
  output logic [LVL_W-1:0]               level_out,
  output logic                           win_valid_out,
`ifdef WINDOW_ARB_STATS_EN
  output logic [16*LEVELS-1:0]           grant_count,
  output logic [15:0]                    stall_count,
`endif
  input  logic                           win_ready_in
);

  logic [LVL_W-1:0]  last_grant;
  logic [LVL_W-1:0]  sel;
  logic [LEVELS-1:0] grant;
  logic              found;
  logic              load_en;
  logic [LVL_W:0]    cand;

  // Cyclic search starting one past the previous winner; first valid level wins.
  always_comb begin
    load_en = !win_valid_out || win_ready_in;
    grant   = '0;
    sel     = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      cand = {1'b0, last_grant} + (LVL_W+1)'(k);
      if (cand >= (LVL_W+1)'(LEVELS)) begin
        cand = cand - (LVL_W+1)'(LEVELS);
      end else begin
        cand = cand;
      end
      if (load_en && !found && win_valid_in[cand[LVL_W-1:0]]) begin
        grant[cand[LVL_W-1:0]] = 1'b1;
        sel                    = cand[LVL_W-1:0];
        found                  = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Upstream must never see a handshake while the block is held in reset.
  assign win_ready_out = grant & {LEVELS{rst}};

  // Output slot: load on transfer, empty on drain without reload, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_out       <= '0;
      level_out     <= '0;
      win_valid_out <= 1'b0;
      last_grant    <= LVL_W'(LEVELS - 1);
    end else if (found) begin
      win_out       <= win_in[int'(sel)*WINDOW_WIDTH +: WINDOW_WIDTH];
      level_out     <= sel;
      win_valid_out <= 1'b1;
      last_grant    <= sel;
    end else if (win_ready_in) begin
      win_valid_out <= 1'b0;
    end else begin
      win_valid_out <= win_valid_out;
    end
  end

`ifdef WINDOW_ARB_STATS_EN
  // Saturating per-level transfer counters and output stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_count <= '0;
      stall_count <= 16'h0000;
    end else begin
      for (int i = 0; i < LEVELS; i++) begin
        if (found && (sel == LVL_W'(i)) && (grant_count[i*16 +: 16] != 16'hFFFF)) begin
          grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'h0001;
        end else begin
          grant_count[i*16 +: 16] <= grant_count[i*16 +: 16];
        end
      end
      if (win_valid_out && !win_ready_in && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'h0001;
      end else begin
        stall_count <= stall_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_arbiter.sv
// Self-checking bench for window_arbiter (LEVELS=4): directed steps plus random traffic vs a reference model.
// Stats checks are compiled in when WINDOW_ARB_STATS_EN is defined.
module tb_window_arbiter;
  localparam int L  = 4;
  localparam int W  = 32;
  localparam int LW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*L-1:0] win_in;
  logic [L-1:0]   win_valid_in;
  logic [L-1:0]   win_ready_out;
  logic [W-1:0]   win_out;
  logic [LW-1:0]  level_out;
  logic           win_valid_out;
  logic           win_ready_in;
`ifdef WINDOW_ARB_STATS_EN
  logic [16*L-1:0] grant_count;
  logic [15:0]     stall_count;
`endif

  always #5 clk = ~clk;

  window_arbiter #(.WINDOW_WIDTH(W), .LEVELS(L)) dut (
    .clk(clk),
    .rst(rst),
    .win_in(win_in),
    .win_valid_in(win_valid_in),
    .win_ready_out(win_ready_out),
    .win_out(win_out),
    .level_out(level_out),
    .win_valid_out(win_valid_out),
`ifdef WINDOW_ARB_STATS_EN
    .grant_count(grant_count),
    .stall_count(stall_count),
`endif
    .win_ready_in(win_ready_in)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: slot contents, round-robin pointer, counters
  bit          m_valid;
  logic [W-1:0] m_win;
  int          m_level;
  int          m_last;
  int          m_gcnt[L];
  int          m_stall;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Level the spec's rule would grant this cycle, or -1 for none.
  function automatic int pick(input logic [L-1:0] v, input logic rdy);
    if (m_valid && !rdy) return -1;
    for (int k = 1; k <= L; k++) begin
      if (v[(m_last + k) % L]) return (m_last + k) % L;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_win   = '0;
    m_level = 0;
    m_last  = L - 1;
    m_stall = 0;
    for (int i = 0; i < L; i++) m_gcnt[i] = 0;
  endtask

  // One clock: drive, check ready, advance the model, check the registered slot after the edge.
  task automatic step(input logic [L-1:0] v, input logic rdy, input logic [W*L-1:0] w);
    int g;
    logic [L-1:0] er;
    win_in       = w;
    win_valid_in = v;
    win_ready_in = rdy;
    #1;
    g  = pick(v, rdy);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("ready", W'(win_ready_out), W'(er));
    if (m_valid && !rdy) m_stall++;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_win   = w[g*W +: W];
      m_level = g;
      m_last  = g;
      m_gcnt[g]++;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_out", W'(win_valid_out), W'(m_valid));
    check("win_out", win_out, m_win);
    check("level_out", W'(level_out), W'(m_level));
  endtask

  function automatic logic [W*L-1:0] rand_wins();
    logic [W*L-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

`ifdef WINDOW_ARB_STATS_EN
  task automatic check_stats(input string tag);
    for (int i = 0; i < L; i++)
      check({tag, "_grant"}, W'(grant_count[i*16 +: 16]), W'(sat16(m_gcnt[i])));
    check({tag, "_stall"}, W'(stall_count), W'(sat16(m_stall)));
  endtask
`endif

  logic [W*L-1:0] w;

  initial begin
    rst          = 1'b0;
    win_in       = '0;
    win_valid_in = '0;
    win_ready_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    win_valid_in = 4'b1111;
    #1;
    check("rst_valid_out", W'(win_valid_out), W'(0));
    check("rst_ready", W'(win_ready_out), W'(0));
    check("rst_level", W'(level_out), W'(0));
    check("rst_win", win_out, W'(0));
    win_valid_in = '0;
    rst = 1'b1;

    // Idle after reset
    step(4'b0000, 1'b1, '0);
    step(4'b0000, 1'b0, '0);
    check("idle_valid_out", W'(win_valid_out), W'(0));

    // Round robin with all levels valid
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, rand_wins());
      check("rr_level", W'(level_out), W'(i % L));
      check("rr_valid", W'(win_valid_out), W'(1));
    end

    // Backpressure on a level-2 window
    w = rand_wins();
    w[2*W +: W] = 32'hA5A5A5A5;
    step(4'b0100, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, rand_wins());
      check("bp_win", win_out, 32'hA5A5A5A5);
      check("bp_level", W'(level_out), W'(2));
    end
    step(4'b1111, 1'b1, rand_wins());
    check("bp_reload_level", W'(level_out), W'(3));
    check("bp_reload_valid", W'(win_valid_out), W'(1));

    // Sparse requesters 1 and 3
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, 1'b1, rand_wins());
      check("sparse_level", W'(level_out), W'((i % 2 == 0) ? 1 : 3));
    end

    // Single window drains to empty
    step(4'b0001, 1'b1, rand_wins());
    check("drain_full", W'(win_valid_out), W'(1));
    step(4'b0000, 1'b1, rand_wins());
    check("drain_empty", W'(win_valid_out), W'(0));
    check("drain_hold_level", W'(level_out), W'(0));

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      step(L'($urandom), ($urandom_range(0, 3) != 0), rand_wins());

`ifdef WINDOW_ARB_STATS_EN
    check_stats("rand");
`endif

    // Asynchronous reset while the slot is full
    step(4'b0001, 1'b0, rand_wins());
    win_valid_in = 4'b1111;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid_out", W'(win_valid_out), W'(0));
    check("midrst_ready", W'(win_ready_out), W'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b1111, 1'b1, rand_wins());
    check("post_rst_level", W'(level_out), W'(0));

`ifdef WINDOW_ARB_STATS_EN
    check_stats("post_rst");
    win_valid_in = 4'b0001;
    win_ready_in = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    m_gcnt[0] += 70000;
    check_stats("sat");
    check("sat_level0", W'(grant_count[15:0]), W'(16'hFFFF));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
